// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Samples a multiplexed active-low seven-segment bus and rebuilds the BCD
//   digit shown on each position. A position commits a new code only after
//   STABLE_CNT consecutive identical accepted samples, which rejects ghosting
//   while the anodes switch.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   sample_en       strobe; an/seg evaluated only when high
//   an[NUM_DIGITS]  anode select, active low (bit i low = position i)
//   seg[6:0]        segments a..g, active low (seg[6]=a)
//   err_clr         clears sticky error flags (a same-cycle set wins)
//   digits          committed code per position, 4 bits each
//   valid           position holds a committed decimal 0..9
//   seg_err         sticky, undecodable pattern committed on that position
//   an_err          sticky, sampled an had more than one bit low
//   update          one-cycle pulse after any commit
//   update_idx      position of the commit that raised update

// One digit position: candidate/count filter plus committed output regs.
module seg_scan_lane #(
  parameter int STABLE_CNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_acc,
  input  logic       i_clr,
  input  logic [3:0] i_code,
  output logic [3:0] o_digit,
  output logic       o_valid,
  output logic       o_seg_err,
  output logic       o_commit
);
  logic [3:0] r_cand, r_cnt, r_digit;
  logic       r_valid, r_seg_err;
  logic       w_same, w_sat;
  logic [3:0] w_next;

  assign w_same = (i_code == r_cand);
  assign w_sat  = (r_cnt == 4'(STABLE_CNT));
  assign w_next = !w_same ? 4'd1 : (w_sat ? r_cnt : r_cnt + 4'd1);
  // Commit only on the sample that reaches the threshold; a saturated
  // count repeating the same code must not fire again.
  assign o_commit = i_acc && !(w_same && w_sat) && (w_next == 4'(STABLE_CNT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand    <= 4'hF;
      r_cnt     <= 4'd0;
      r_digit   <= 4'hF;
      r_valid   <= 1'b0;
      r_seg_err <= 1'b0;
    end else begin
      if (i_acc) begin
        r_cand <= i_code;
        r_cnt  <= w_next;
      end
      if (o_commit) begin
        r_digit <= i_code;
        r_valid <= (i_code <= 4'd9);
      end
      if (o_commit && i_code == 4'hE) r_seg_err <= 1'b1;
      else if (i_clr)                 r_seg_err <= 1'b0;
    end
  end

  assign o_digit   = r_digit;
  assign o_valid   = r_valid;
  assign o_seg_err = r_seg_err;
endmodule

module seg_scan_decoder #(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_en,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   valid,
  output logic [NUM_DIGITS-1:0]   seg_err,
  output logic                    an_err,
  output logic                    update,
  output logic [2:0]              update_idx
);
  logic [3:0]                  w_code;
  logic [NUM_DIGITS-1:0]       w_nlow, w_acc, w_commit;
  logic                        w_one, w_multi;
  logic [2:0]                  w_idx;
  logic [NUM_DIGITS-1:0][3:0]  w_digit;
  logic                        r_an_err, r_update;
  logic [2:0]                  r_idx;

  always_comb begin
    case (seg)
      7'b0000001: w_code = 4'd0;
      7'b1001111: w_code = 4'd1;
      7'b0010010: w_code = 4'd2;
      7'b0000110: w_code = 4'd3;
      7'b1001100: w_code = 4'd4;
      7'b0100100: w_code = 4'd5;
      7'b0100000: w_code = 4'd6;
      7'b0001111: w_code = 4'd7;
      7'b0000000: w_code = 4'd8;
      7'b0000100: w_code = 4'd9;
      7'b1111111: w_code = 4'hF;
      default:    w_code = 4'hE;
    endcase
  end

  // Exactly one anode low <=> nonzero with a single set bit in ~an.
  assign w_nlow  = ~an;
  assign w_one   = (w_nlow != '0) && ((w_nlow & (w_nlow - NUM_DIGITS'(1))) == '0);
  assign w_multi = (w_nlow != '0) && !w_one;
  assign w_acc   = (sample_en && w_one) ? w_nlow : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lane
      seg_scan_lane #(.STABLE_CNT(STABLE_CNT)) u_lane (
        .clk       (clk),
        .rst       (rst),
        .i_acc     (w_acc[gi]),
        .i_clr     (err_clr),
        .i_code    (w_code),
        .o_digit   (w_digit[gi]),
        .o_valid   (valid[gi]),
        .o_seg_err (seg_err[gi]),
        .o_commit  (w_commit[gi])
      );
    end
  endgenerate

  // At most one lane commits per cycle since acceptance is one-hot.
  always_comb begin
    w_idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (w_commit[i]) w_idx = 3'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an_err <= 1'b0;
      r_update <= 1'b0;
      r_idx    <= 3'd0;
    end else begin
      if (sample_en && w_multi) r_an_err <= 1'b1;
      else if (err_clr)         r_an_err <= 1'b0;
      r_update <= |w_commit;
      if (|w_commit) r_idx <= w_idx;
    end
  end

  assign digits     = w_digit;
  assign an_err     = r_an_err;
  assign update     = r_update;
  assign update_idx = r_idx;
endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;
  localparam int ND = 4;
  localparam int SC = 3;

  logic clk = 1'b0;
  logic rst, sample_en, err_clr;
  logic [ND-1:0] an;
  logic [6:0] seg;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] valid, seg_err;
  logic an_err, update;
  logic [2:0] update_idx;

  seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CNT(SC)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .an(an), .seg(seg),
    .err_clr(err_clr), .digits(digits), .valid(valid), .seg_err(seg_err),
    .an_err(an_err), .update(update), .update_idx(update_idx)
  );

  always #5 clk = ~clk;

  int nchk = 0, npass = 0;

  // ---------------- reference model ----------------
  logic [6:0] enc [10];
  int         m_run  [ND];
  logic [3:0] m_last [ND];
  logic [15:0] m_dig;
  logic [3:0]  m_val, m_se;
  logic        m_ae, m_upd;
  logic [2:0]  m_idx;

  function automatic logic [3:0] mdec(input logic [6:0] s);
    for (int k = 0; k < 10; k++) if (s == enc[k]) return 4'(k);
    if (s == 7'h7F) return 4'hF;
    return 4'hE;
  endfunction

  task automatic model(input logic r, en, clr, input logic [3:0] a, input logic [6:0] s);
    int nz, pos;
    logic [3:0] d;
    if (r) begin
      for (int i = 0; i < ND; i++) begin m_run[i] = 0; m_last[i] = 4'hF; end
      m_dig = 16'hFFFF; m_val = '0; m_se = '0; m_ae = 0; m_upd = 0; m_idx = 0;
      return;
    end
    m_upd = 0;
    if (clr) begin m_se = '0; m_ae = 0; end
    if (!en) return;
    nz = 0; pos = 0;
    for (int i = 0; i < ND; i++) if (!a[i]) begin nz++; pos = i; end
    if (nz > 1) m_ae = 1;
    if (nz != 1) return;
    d = mdec(s);
    if (d == m_last[pos]) m_run[pos]++;
    else begin m_last[pos] = d; m_run[pos] = 1; end
    if (m_run[pos] == SC) begin
      m_dig[4*pos +: 4] = d;
      m_val[pos] = (d <= 9);
      if (d == 4'hE) m_se[pos] = 1;
      m_upd = 1; m_idx = 3'(pos);
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [31:0] dut_out();
    return 32'({digits, valid, seg_err, an_err, update, update_idx});
  endfunction

  task automatic step(input logic r, en, clr, input logic [3:0] a, input logic [6:0] s);
    rst = r; sample_en = en; err_clr = clr; an = a; seg = s;
    @(posedge clk);
    model(r, en, clr, a, s);
    #1;
    chk("model", dut_out(), 32'({m_dig, m_val, m_se, m_ae, m_upd, m_idx}));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic r, en, clr;
    logic [3:0] a;
    logic [6:0] s;
    logic [15:0] dig;
    logic [3:0] vld, se;
    logic ae, upd;
    logic [2:0] idx;
  } vec_t;

  function automatic vec_t mk(logic r, en, clr, logic [3:0] a, logic [6:0] s,
                              logic [15:0] dig, logic [3:0] vld, se,
                              logic ae, upd, logic [2:0] idx);
    vec_t v;
    v.r = r; v.en = en; v.clr = clr; v.a = a; v.s = s; v.dig = dig;
    v.vld = vld; v.se = se; v.ae = ae; v.upd = upd; v.idx = idx;
    return v;
  endfunction

  vec_t tbl [19];
  logic [6:0] cur_seg [ND];

  initial begin
    enc = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};
    // State entering the table: digits 4321, all valid.
    tbl[0]  = mk(0,1,0,4'b1011,7'h24, 16'h4321,4'b1111,4'b0000,0,0,3);
    tbl[1]  = mk(0,1,0,4'b1011,7'h24, 16'h4321,4'b1111,4'b0000,0,0,3);
    tbl[2]  = mk(0,1,0,4'b1011,7'h24, 16'h4521,4'b1111,4'b0000,0,1,2);
    tbl[3]  = mk(0,0,0,4'b1011,7'h24, 16'h4521,4'b1111,4'b0000,0,0,2);
    tbl[4]  = mk(0,1,0,4'b1110,7'h24, 16'h4521,4'b1111,4'b0000,0,0,2);
    tbl[5]  = mk(0,1,0,4'b1110,7'h06, 16'h4521,4'b1111,4'b0000,0,0,2);
    tbl[6]  = mk(0,1,0,4'b1110,7'h24, 16'h4521,4'b1111,4'b0000,0,0,2);
    tbl[7]  = mk(0,1,0,4'b1101,7'h77, 16'h4521,4'b1111,4'b0000,0,0,2);
    tbl[8]  = mk(0,1,0,4'b1101,7'h77, 16'h4521,4'b1111,4'b0000,0,0,2);
    tbl[9]  = mk(0,1,0,4'b1101,7'h77, 16'h45E1,4'b1101,4'b0010,0,1,1);
    tbl[10] = mk(0,1,0,4'b0111,7'h77, 16'h45E1,4'b1101,4'b0010,0,0,1);
    tbl[11] = mk(0,1,0,4'b0111,7'h77, 16'h45E1,4'b1101,4'b0010,0,0,1);
    tbl[12] = mk(0,1,1,4'b0111,7'h77, 16'hE5E1,4'b0101,4'b1000,0,1,3);
    tbl[13] = mk(0,1,0,4'b1100,7'h24, 16'hE5E1,4'b0101,4'b1000,1,0,3);
    tbl[14] = mk(0,1,0,4'b1111,7'h24, 16'hE5E1,4'b0101,4'b1000,1,0,3);
    tbl[15] = mk(0,0,0,4'b1110,7'h4F, 16'hE5E1,4'b0101,4'b1000,1,0,3);
    tbl[16] = mk(0,0,1,4'b1110,7'h4F, 16'hE5E1,4'b0101,4'b0000,0,0,3);
    tbl[17] = mk(0,1,1,4'b1100,7'h4F, 16'hE5E1,4'b0101,4'b0000,1,0,3);
    tbl[18] = mk(1,0,0,4'b1111,7'h7F, 16'hFFFF,4'b0000,4'b0000,0,0,0);

    rst = 1; sample_en = 0; err_clr = 0; an = '1; seg = 7'h7F;
    step(1,0,0,4'b1111,7'h7F);
    chk("reset", dut_out(), 32'({16'hFFFF, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0}));

    // Full scan of 1,2,3,4 on positions 0..3, three rounds.
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < ND; k++) begin
        step(0,1,0, ~(4'b0001 << k), enc[k+1]);
        if (r == 2) chk("scan_upd", {29'd0, update, update_idx}, {29'd0, 1'b1, 3'(k)});
        else        chk("scan_hold", {31'd0, update}, 32'd0);
      end
    chk("scan_final", {12'd0, digits, valid}, {12'd0, 16'h4321, 4'hF});

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].r, tbl[i].en, tbl[i].clr, tbl[i].a, tbl[i].s);
      chk($sformatf("tbl%0d", i), dut_out(),
          32'({tbl[i].dig, tbl[i].vld, tbl[i].se, tbl[i].ae, tbl[i].upd, tbl[i].idx}));
    end

    // Partial count discarded by a mid-operation reset.
    for (int i = 0; i < 3; i++) step(0,1,0,4'b1110,7'h0F);
    chk("commit7", {10'd0, digits, valid, update, update_idx},
        {10'd0, 16'hFFF7, 4'b0001, 1'b1, 3'd0});
    for (int i = 0; i < 2; i++) step(0,1,0,4'b1110,7'h00);
    chk("partial8", {11'd0, digits, valid, update}, {11'd0, 16'hFFF7, 4'b0001, 1'b0});
    step(1,1,0,4'b1110,7'h00);
    chk("midrst", dut_out(), 32'({16'hFFFF, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0}));
    step(0,1,0,4'b1110,7'h00);
    chk("post_rst_one", {11'd0, digits, valid, update}, {11'd0, 16'hFFFF, 4'b0000, 1'b0});

    // Randomized traffic; segments are sticky per position so runs form.
    for (int i = 0; i < ND; i++) cur_seg[i] = 7'h7F;
    for (int n = 0; n < 3000; n++) begin
      logic [6:0] pool [8];
      logic [3:0] a;
      int p, sel;
      pool = '{7'h01, 7'h4F, 7'h24, 7'h7F, 7'h77, 7'h00, 7'h04, 7'h6B};
      sel = int'($urandom_range(0, 9));
      p = int'($urandom_range(0, ND-1));
      if (sel < 7)       a = ~(4'b0001 << p);
      else if (sel == 7) a = 4'b1111;
      else if (sel == 8) a = 4'($urandom);
      else               a = 4'b1100;
      if ($urandom_range(0, 6) == 0) cur_seg[p] = pool[$urandom_range(0, 7)];
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 29) == 0, a, cur_seg[p]);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
